// File: rtl/mem_access_seq_if.sv
// Request/response bus between the control unit and mem_access_seq.
// The control unit owns the master modport; the sequencer owns the slave modport.
interface mem_access_seq_if;
  logic       reqValid;
  logic       reqReady;
  logic [1:0] reqOp;
  logic       reqIndirect;
  logic [7:0] reqAddr;
  logic [7:0] reqData;
  logic       respValid;
  logic [7:0] respData;
  logic       respErr;

  modport master (
    output reqValid, reqOp, reqIndirect, reqAddr, reqData,
    input  reqReady, respValid, respData, respErr
  );

  modport slave (
    input  reqValid, reqOp, reqIndirect, reqAddr, reqData,
    output reqReady, respValid, respData, respErr
  );
endinterface

// File: rtl/mem_access_seq.sv
// mem_access_seq: single-outstanding load/store sequencer in front of the
// 8-bit memory. Accepts one request at a time, drives the memory pins,
// waits out the fixed MEM_LATENCY and returns read data or a write ack.
// Indirect requests are resolved here: the pointer word is read first and
// the real access is issued at that pointer, so the memory only ever sees
// direct accesses.
//
// Optional feature: define MEM_ACCESS_COUNT_EN to enable accessCount, a
// CNT_W-bit count of completed, non-error transactions. Without the macro
// accessCount is tied to 0 and the port list is unchanged.
//
// Reset: resetN asserts asynchronously; its deassertion is expected to be
// synchronised to clk upstream of this block.
//
// Output timing: every output is a flop loaded on the edge that enters the
// state it belongs to, so a request accepted at edge T shows memStart in
// the cycle right after T, and a direct op shows respValid MEM_LATENCY+2
// cycles after T (indirect: 2*MEM_LATENCY+3, reserved op: 1).
module mem_access_seq #(
  parameter int MEM_LATENCY = 1,  // legal range 1..7
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             resetN,
  mem_access_seq_if.slave  req_bus,
  output logic             memStart,
  output logic [1:0]       memCntrl,
  output logic [7:0]       memAddr,
  output logic [7:0]       memDataIn,
  input  logic [7:0]       memDataOut,
  output logic [CNT_W-1:0] accessCount
);

  localparam logic [1:0] OP_RD      = 2'b01;
  localparam logic [1:0] OP_WR      = 2'b10;
  localparam logic [1:0] CNTRL_IDLE = 2'b00;

  // Counter reload: the memory data is valid MEM_LATENCY cycles after the
  // start pulse, and the wait state is entered one cycle after that pulse.
  localparam logic [2:0] WAIT_LOAD  = 3'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PTR_ISSUE = 3'd1,
    ST_PTR_WAIT  = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT      = 3'd4,
    ST_RESP      = 3'd5
  } state_t;

  state_t     state_r;
  logic [2:0] wait_cnt_r;   // remaining cycles until memDataOut is valid
  logic [1:0] op_r;         // latched request op (only 01/10 reach ISSUE)
  logic [7:0] data_r;       // latched write data

  // Reserved encodings are anything that is neither a read nor a write.
  function automatic logic is_reserved(input logic [1:0] op);
    return (op != OP_RD) && (op != OP_WR);
  endfunction

  // Write data presented to the memory: latched data on writes, zero on reads.
  function automatic logic [7:0] issue_data(input logic [1:0] op, input logic [7:0] data);
    return (op == OP_WR) ? data : 8'h00;
  endfunction

  // Main sequencer FSM; all request/response and memory outputs are registered here.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r           <= ST_IDLE;
      wait_cnt_r        <= 3'd0;
      op_r              <= 2'b00;
      data_r            <= 8'h00;
      req_bus.reqReady  <= 1'b1;
      req_bus.respValid <= 1'b0;
      req_bus.respData  <= 8'h00;
      req_bus.respErr   <= 1'b0;
      memStart          <= 1'b0;
      memCntrl          <= CNTRL_IDLE;
      memAddr           <= 8'h00;
      memDataIn         <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          req_bus.respValid <= 1'b0;
          req_bus.respErr   <= 1'b0;
          memStart          <= 1'b0;
          memCntrl          <= CNTRL_IDLE;
          if (req_bus.reqValid && req_bus.reqReady) begin
            op_r             <= req_bus.reqOp;
            data_r           <= req_bus.reqData;
            req_bus.reqReady <= 1'b0;
            if (is_reserved(req_bus.reqOp)) begin
              // No memory access at all; answer with an error next cycle.
              req_bus.respValid <= 1'b1;
              req_bus.respErr   <= 1'b1;
              state_r           <= ST_RESP;
            end else if (req_bus.reqIndirect) begin
              // Fetch the pointer word first.
              memStart <= 1'b1;
              memCntrl <= OP_RD;
              memAddr  <= req_bus.reqAddr;
              state_r  <= ST_PTR_ISSUE;
            end else begin
              memStart  <= 1'b1;
              memCntrl  <= req_bus.reqOp;
              memAddr   <= req_bus.reqAddr;
              memDataIn <= issue_data(req_bus.reqOp, req_bus.reqData);
              state_r   <= ST_ISSUE;
            end
          end else begin
            req_bus.reqReady <= 1'b1;
            state_r          <= ST_IDLE;
          end
        end

        ST_PTR_ISSUE: begin
          memStart   <= 1'b0;
          memCntrl   <= CNTRL_IDLE;
          wait_cnt_r <= WAIT_LOAD;
          state_r    <= ST_PTR_WAIT;
        end

        ST_PTR_WAIT: begin
          if (wait_cnt_r == 3'd0) begin
            // Pointer word is valid now: it becomes the effective address.
            memStart  <= 1'b1;
            memCntrl  <= op_r;
            memAddr   <= memDataOut;
            memDataIn <= issue_data(op_r, data_r);
            state_r   <= ST_ISSUE;
          end else begin
            wait_cnt_r <= wait_cnt_r - 3'd1;
          end
        end

        ST_ISSUE: begin
          memStart   <= 1'b0;
          memCntrl   <= CNTRL_IDLE;
          wait_cnt_r <= WAIT_LOAD;
          state_r    <= ST_WAIT;
        end

        ST_WAIT: begin
          if (wait_cnt_r == 3'd0) begin
            if (op_r == OP_RD) begin
              req_bus.respData <= memDataOut;
            end else begin
              req_bus.respData <= req_bus.respData;
            end
            req_bus.respValid <= 1'b1;
            req_bus.respErr   <= 1'b0;
            state_r           <= ST_RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r - 3'd1;
          end
        end

        ST_RESP: begin
          req_bus.respValid <= 1'b0;
          req_bus.respErr   <= 1'b0;
          req_bus.reqReady  <= 1'b1;
          state_r           <= ST_IDLE;
        end

        default: begin
          req_bus.respValid <= 1'b0;
          req_bus.respErr   <= 1'b0;
          req_bus.reqReady  <= 1'b1;
          memStart          <= 1'b0;
          memCntrl          <= CNTRL_IDLE;
          state_r           <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ACCESS_COUNT_EN
  // Count completed non-error transactions; wraps naturally at all-ones.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      accessCount <= '0;
    end else if (req_bus.respValid && !req_bus.respErr) begin
      accessCount <= accessCount + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      accessCount <= accessCount;
    end
  end
`else
  assign accessCount = '0;
`endif

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed self-checking bench for mem_access_seq. Two instances are used:
// d1 with MEM_LATENCY=1 for most checks and d3 with MEM_LATENCY=3 for the
// long-latency indirect access and the mid-transaction reset.
module tb_mem_access_seq;

`ifdef MEM_ACCESS_COUNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic clk;
  logic resetN;

  mem_access_seq_if bus1 ();
  mem_access_seq_if bus3 ();

  logic        memStart1, memStart3;
  logic [1:0]  memCntrl1, memCntrl3;
  logic [7:0]  memAddr1, memAddr3;
  logic [7:0]  memDataIn1, memDataIn3;
  logic [7:0]  memDataOut1 = 8'h00;
  logic [7:0]  memDataOut3 = 8'h00;
  logic [15:0] accessCount1, accessCount3;

  logic [7:0]  mem1 [256];
  logic [7:0]  mem3 [256];
  logic [7:0]  p3_0 = 8'h00;
  logic [7:0]  p3_1 = 8'h00;
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = 8'h00;
  logic [7:0]  pre_data = 8'h00;

  int vectors = 0;
  int miscompares = 0;

  mem_access_seq #(.MEM_LATENCY(1), .CNT_W(16)) d1 (
    .clk(clk), .resetN(resetN), .req_bus(bus1.slave),
    .memStart(memStart1), .memCntrl(memCntrl1), .memAddr(memAddr1),
    .memDataIn(memDataIn1), .memDataOut(memDataOut1), .accessCount(accessCount1)
  );

  mem_access_seq #(.MEM_LATENCY(3), .CNT_W(16)) d3 (
    .clk(clk), .resetN(resetN), .req_bus(bus3.slave),
    .memStart(memStart3), .memCntrl(memCntrl3), .memAddr(memAddr3),
    .memDataIn(memDataIn3), .memDataOut(memDataOut3), .accessCount(accessCount3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: latency 1 for d1, a 3-stage read pipe for d3.
  always @(posedge clk) begin
    if (pre_we) begin
      mem1[pre_addr] <= pre_data;
      mem3[pre_addr] <= pre_data;
    end else begin
      if (memStart1 && memCntrl1 == 2'b10) mem1[memAddr1] <= memDataIn1;
      if (memStart3 && memCntrl3 == 2'b10) mem3[memAddr3] <= memDataIn3;
    end
    if (memStart1 && memCntrl1 == 2'b01) memDataOut1 <= mem1[memAddr1];
    if (memStart3 && memCntrl3 == 2'b01) p3_0 <= mem3[memAddr3];
    p3_1        <= p3_0;
    memDataOut3 <= p3_1;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_we = 1'b0;
  endtask

  // Present a request on bus1 for one edge; returns in the cycle after accept.
  task automatic send1(input logic [1:0] op, input logic ind, input logic [7:0] a, input logic [7:0] d);
    bus1.reqOp = op; bus1.reqIndirect = ind; bus1.reqAddr = a; bus1.reqData = d;
    bus1.reqValid = 1'b1;
    step();
    bus1.reqValid = 1'b0;
    // Later input changes must not matter.
    bus1.reqOp = 2'b11; bus1.reqAddr = 8'hAA; bus1.reqData = 8'h5F; bus1.reqIndirect = ~ind;
  endtask

  // Full transaction on d1 with bounded wait for respValid.
  task automatic run_op1(input string tag, input logic [1:0] op, input logic ind,
                         input logic [7:0] a, input logic [7:0] d, input int exp_lat,
                         input logic [7:0] exp_data, input logic exp_err);
    int k;
    send1(op, ind, a, d);
    k = 1;
    while (bus1.respValid !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    chk({tag, ".resp"}, 32'(bus1.respValid), 32'd1);
    chk({tag, ".lat"}, k, exp_lat);
    chk({tag, ".data"}, 32'(bus1.respData), 32'(exp_data));
    chk({tag, ".err"}, 32'(bus1.respErr), 32'(exp_err));
    step();
    chk({tag, ".ready"}, 32'(bus1.reqReady), 32'd1);
  endtask

  initial begin
    int k;
    int pulses;
    int resp_cnt;
    logic [7:0] first_addr;
    logic [7:0] second_addr;

    resetN = 1'b0;
    bus1.reqValid = 1'b0; bus1.reqOp = 2'b00; bus1.reqIndirect = 1'b0; bus1.reqAddr = 8'h00; bus1.reqData = 8'h00;
    bus3.reqValid = 1'b0; bus3.reqOp = 2'b00; bus3.reqIndirect = 1'b0; bus3.reqAddr = 8'h00; bus3.reqData = 8'h00;
    step();
    preload(8'h20, 8'h5A);
    preload(8'h10, 8'h40);
    preload(8'h40, 8'h99);
    preload(8'hFF, 8'hE7);

    // Reset state
    chk("rst.ready", 32'(bus1.reqReady), 32'd1);
    chk("rst.respValid", 32'(bus1.respValid), 32'd0);
    chk("rst.respData", 32'(bus1.respData), 32'd0);
    chk("rst.respErr", 32'(bus1.respErr), 32'd0);
    chk("rst.memStart", 32'(memStart1), 32'd0);
    chk("rst.memCntrl", 32'(memCntrl1), 32'd0);
    chk("rst.memAddr", 32'(memAddr1), 32'd0);
    chk("rst.memDataIn", 32'(memDataIn1), 32'd0);
    chk("rst.count", 32'(accessCount1), 32'd0);
    resetN = 1'b1;
    step();

    // Direct read of [20]
    send1(2'b01, 1'b0, 8'h20, 8'h00);
    chk("rd.start", 32'(memStart1), 32'd1);
    chk("rd.addr", 32'(memAddr1), 32'h20);
    chk("rd.cntrl", 32'(memCntrl1), 32'h1);
    chk("rd.ready", 32'(bus1.reqReady), 32'd0);
    step();
    chk("rd.start_t2", 32'(memStart1), 32'd0);
    chk("rd.cntrl_t2", 32'(memCntrl1), 32'd0);
    chk("rd.resp_t2", 32'(bus1.respValid), 32'd0);
    step();
    chk("rd.resp_t3", 32'(bus1.respValid), 32'd1);
    chk("rd.data_t3", 32'(bus1.respData), 32'h5A);
    chk("rd.err_t3", 32'(bus1.respErr), 32'd0);
    step();
    chk("rd.resp_t4", 32'(bus1.respValid), 32'd0);
    chk("rd.ready_t4", 32'(bus1.reqReady), 32'd1);
    chk("rd.hold_t4", 32'(bus1.respData), 32'h5A);
    chk("rd.count", 32'(accessCount1), 32'(CNT_ON * 1));

    // Direct write C3 -> [07]
    send1(2'b10, 1'b0, 8'h07, 8'hC3);
    chk("wr.start", 32'(memStart1), 32'd1);
    chk("wr.cntrl", 32'(memCntrl1), 32'h2);
    chk("wr.addr", 32'(memAddr1), 32'h07);
    chk("wr.dataIn", 32'(memDataIn1), 32'hC3);
    step();
    step();
    chk("wr.resp_t3", 32'(bus1.respValid), 32'd1);
    chk("wr.err_t3", 32'(bus1.respErr), 32'd0);
    chk("wr.data_hold", 32'(bus1.respData), 32'h5A);
    step();
    chk("wr.count", 32'(accessCount1), 32'(CNT_ON * 2));
    run_op1("rdback", 2'b01, 1'b0, 8'h07, 8'h00, 3, 8'hC3, 1'b0);

    // Indirect read LAT=1: [10]=40 -> [40]=99
    send1(2'b01, 1'b1, 8'h10, 8'h00);
    chk("ind1.start1", 32'(memStart1), 32'd1);
    chk("ind1.addr1", 32'(memAddr1), 32'h10);
    chk("ind1.cntrl1", 32'(memCntrl1), 32'h1);
    step();
    chk("ind1.gap", 32'(memStart1), 32'd0);
    step();
    chk("ind1.start2", 32'(memStart1), 32'd1);
    chk("ind1.addr2", 32'(memAddr1), 32'h40);
    chk("ind1.cntrl2", 32'(memCntrl1), 32'h1);
    chk("ind1.dataIn_rd", 32'(memDataIn1), 32'h00);
    step();
    chk("ind1.resp_t4", 32'(bus1.respValid), 32'd0);
    step();
    chk("ind1.resp_t5", 32'(bus1.respValid), 32'd1);
    chk("ind1.data_t5", 32'(bus1.respData), 32'h99);
    step();
    chk("ind1.count", 32'(accessCount1), 32'(CNT_ON * 4));

    // Indirect read LAT=3 on d3
    bus3.reqOp = 2'b01; bus3.reqIndirect = 1'b1; bus3.reqAddr = 8'h10; bus3.reqValid = 1'b1;
    step();
    bus3.reqValid = 1'b0; bus3.reqAddr = 8'h33;
    k = 1; pulses = 0; first_addr = 8'h00; second_addr = 8'h00;
    while (bus3.respValid !== 1'b1 && k < 40) begin
      if (memStart3 === 1'b1) begin
        if (pulses == 0) first_addr = memAddr3;
        else second_addr = memAddr3;
        pulses++;
      end
      step();
      k++;
    end
    chk("ind3.resp", 32'(bus3.respValid), 32'd1);
    chk("ind3.lat", k, 9);
    chk("ind3.pulses", pulses, 2);
    chk("ind3.addr1", 32'(first_addr), 32'h10);
    chk("ind3.addr2", 32'(second_addr), 32'h40);
    chk("ind3.data", 32'(bus3.respData), 32'h99);
    step();

    // Reserved op 11
    send1(2'b11, 1'b0, 8'h20, 8'h00);
    chk("rsv.resp", 32'(bus1.respValid), 32'd1);
    chk("rsv.err", 32'(bus1.respErr), 32'd1);
    chk("rsv.start_t1", 32'(memStart1), 32'd0);
    step();
    chk("rsv.resp_t2", 32'(bus1.respValid), 32'd0);
    chk("rsv.ready_t2", 32'(bus1.reqReady), 32'd1);
    chk("rsv.start_t2", 32'(memStart1), 32'd0);
    chk("rsv.count", 32'(accessCount1), 32'(CNT_ON * 4));

    // Busy: second request held through the transaction is ignored
    bus1.reqOp = 2'b01; bus1.reqIndirect = 1'b0; bus1.reqAddr = 8'h20; bus1.reqValid = 1'b1;
    step();
    bus1.reqAddr = 8'h07;
    resp_cnt = 0;
    for (int i = 1; i <= 7; i++) begin
      if (bus1.respValid === 1'b1) resp_cnt++;
      if (i <= 3) chk("busy.ready", 32'(bus1.reqReady), 32'd0);
      if (i == 3) bus1.reqValid = 1'b0;
      step();
    end
    chk("busy.resp_cnt", resp_cnt, 1);
    chk("busy.data", 32'(bus1.respData), 32'h5A);
    chk("busy.count", 32'(accessCount1), 32'(CNT_ON * 5));

    // Boundary address FF used as-is
    run_op1("rdFF", 2'b01, 1'b0, 8'hFF, 8'h00, 3, 8'hE7, 1'b0);
    chk("rdFF.count", 32'(accessCount1), 32'(CNT_ON * 6));

    // Reset during PTR_WAIT on d3
    bus3.reqOp = 2'b01; bus3.reqIndirect = 1'b1; bus3.reqAddr = 8'h10; bus3.reqValid = 1'b1;
    step();
    bus3.reqValid = 1'b0;
    chk("rstmid.start", 32'(memStart3), 32'd1);
    step();
    chk("rstmid.ptrwait", 32'(memStart3), 32'd0);
    resetN = 1'b0;
    #1;
    chk("rstmid.memStart", 32'(memStart3), 32'd0);
    chk("rstmid.memCntrl", 32'(memCntrl3), 32'd0);
    chk("rstmid.memAddr", 32'(memAddr3), 32'd0);
    chk("rstmid.respData", 32'(bus3.respData), 32'd0);
    chk("rstmid.ready", 32'(bus3.reqReady), 32'd1);
    chk("rstmid.count1", 32'(accessCount1), 32'd0);
    step();
    resetN = 1'b1;
    resp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus3.respValid === 1'b1) resp_cnt++;
      step();
    end
    chk("rstmid.noresp", resp_cnt, 0);
    chk("rstmid.ready_after", 32'(bus3.reqReady), 32'd1);

    // Counter: 3 valid ops + 1 reserved
    run_op1("cnt.rd", 2'b01, 1'b0, 8'h20, 8'h00, 3, 8'h5A, 1'b0);
    run_op1("cnt.wr", 2'b10, 1'b0, 8'h07, 8'h11, 3, 8'h5A, 1'b0);
    run_op1("cnt.rd2", 2'b01, 1'b0, 8'h07, 8'h00, 3, 8'h11, 1'b0);
    run_op1("cnt.rsv", 2'b00, 1'b0, 8'h07, 8'h00, 1, 8'h11, 1'b1);
    chk("cnt.total", 32'(accessCount1), 32'(CNT_ON * 3));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Sequencer sitting directly upstream of the 8-bit memory module.
- Accepts load/store requests from the control unit and drives the memory's start/cntrl/addr/dataIn pins.
- Waits out the memory's fixed access latency and returns read data or a write acknowledge.
- Resolves indirect addressing itself: reads a pointer word first, then performs the real access at that pointer. The memory therefore only ever sees direct accesses.

Parameters:
- MEM_LATENCY, 1: cycles from the memStart pulse until memDataOut is valid (legal range 1-7).
- CNT_W, 16: width of accessCount.

Ports:
- clk  in  1  system clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- reqValid  in  1  request present.
- reqReady  out  1  sequencer can accept a request; high only in IDLE.
- reqOp  in  2  2'b01 read, 2'b10 write, 2'b00/2'b11 reserved.
- reqIndirect  in  1  treat reqAddr as a pointer location.
- reqAddr  in  8  direct address or pointer location.
- reqData  in  8  write data.
- respValid  out  1  one-cycle completion pulse.
- respData  out  8  read data; held until the next respValid.
- respErr  out  1  reserved op; valid with respValid.
- memStart  out  1  one-cycle start pulse to the memory.
- memCntrl  out  2  2'b01 read, 2'b10 write, 2'b00 idle.
- memAddr  out  8  memory address.
- memDataIn  out  8  memory write data.
- memDataOut  in  8  memory read data.
- accessCount  out  CNT_W  completed transactions (optional feature).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, reqReady=1.
  - All other outputs 0: respValid, respData, respErr, memStart, memCntrl, memAddr, memDataIn, accessCount.
  - Wait counter is cleared.
- Reset mid-transaction: the transaction is abandoned with no respValid. memStart and memCntrl drop to 0 immediately.
- All outputs are registered.
- Accept rule: a request is accepted when reqValid && reqReady at a rising edge (call this cycle T).
  - reqOp, reqIndirect, reqAddr and reqData are latched at T.
  - reqReady drops at T+1.
- States: IDLE, PTR_ISSUE, PTR_WAIT, ISSUE, WAIT, RESP.
- IDLE:
  - accept with reserved op -> RESP, with respErr=1 and no memory access.
  - accept with reqIndirect=1 -> PTR_ISSUE.
  - any other accept -> ISSUE.
- PTR_ISSUE (1 cycle):
  - memStart=1, memCntrl=01, memAddr=latched addr.
  - Wait counter loads MEM_LATENCY-1 -> PTR_WAIT.
- PTR_WAIT:
  - Counts down while memStart=0 and memCntrl=00.
  - At count 0, memDataOut is latched as the effective address -> ISSUE.
- ISSUE (1 cycle):
  - memStart=1, memCntrl=op, memAddr=effective address.
  - memDataIn=latched data on writes; 0 on reads.
  - -> WAIT.
- WAIT:
  - Counts down as in PTR_WAIT.
  - At count 0: reads latch memDataOut into respData; writes leave respData unchanged.
  - -> RESP.
- RESP (1 cycle):
  - respValid=1; respErr=1 only for a reserved op.
  - -> IDLE, with reqReady=1 again in the following cycle.
- Latency from T to respValid:
  - direct op: MEM_LATENCY+2 cycles.
  - indirect op: 2*MEM_LATENCY+3 cycles.
  - reserved op: 1 cycle.
- Back-to-back: a new request can be accepted in the cycle after RESP. There is no pipelining; exactly one outstanding transaction.
- reqValid while reqReady=0 is ignored and not queued. Input changes after T have no effect.
- Address arithmetic: none. An 8'hFF pointer or address is used as-is; there is no wrap logic.
- memAddr and memDataIn hold their last values outside ISSUE states. memCntrl returns to 00.

Optional Feature:
- Macro MEM_ACCESS_COUNT_EN.
- Defined:
  - accessCount increments by 1 on every respValid with respErr=0.
  - It wraps from all-ones to 0 and is cleared by resetN.
- Undefined:
  - No counter logic; accessCount is tied to 0.
  - Port list is unchanged.

Test Plan:
- Direct read, MEM_LATENCY=1: memory preloaded [8'h20]=8'h5A; reqOp=01, reqAddr=8'h20 accepted at T.
  - memStart=1 at T+1 with memAddr=8'h20, memCntrl=01.
  - respValid=1 and respData=8'h5A at T+3.
- Direct write then read back: write 8'hC3 to 8'h07.
  - memStart=1 at T+1 with memCntrl=10, memDataIn=8'hC3; respValid at T+3, respErr=0.
  - A following read of 8'h07 returns 8'hC3.
- Indirect read: [8'h10]=8'h40, [8'h40]=8'h99; reqIndirect=1, reqAddr=8'h10.
  - Two memStart pulses: the first with memAddr=8'h10, the second with memAddr=8'h40.
  - respData=8'h99 at T+5; the same access with MEM_LATENCY=3 completes at T+9.
- Reserved op 2'b11: respValid and respErr=1 at T+1.
  - memStart stays 0 throughout; accessCount is unchanged (feature on).
- Busy and reset:
  - A second reqValid held during WAIT is ignored: only one respValid, reqReady=0 until after RESP.
  - resetN pulsed low during PTR_WAIT: all outputs go to 0 immediately, no respValid, reqReady=1 after release.
- Counter with MEM_ACCESS_COUNT_EN: 3 valid ops plus 1 reserved op gives accessCount=3; with the macro undefined, accessCount stays 0.
